// File: rtl/lis3dh_poller.sv
// LIS3DH poller: WHO_AM_I check, CTRL_REG1 setup, then periodic OUT_X burst reads.
// Define LIS3DH_XYZ_EN to widen the burst to X/Y/Z and add sample_y/sample_z.
module lis3dh_poller #(
    parameter logic [31:0] POLL_DIV     = 32'd1000,
    parameter logic [7:0]  WHOAMI_EXP   = 8'h33,
    parameter logic [7:0]  CTRL1_VAL    = 8'h57,
    parameter logic [15:0] XFER_TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    output logic        xfer_hold,
    input  logic        xfer_busy,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic [15:0] sample_x,
`ifdef LIS3DH_XYZ_EN
    output logic [15:0] sample_y,
    output logic [15:0] sample_z,
`endif
    output logic        sample_valid,
    output logic        dev_ok,
    output logic        fault,
    output logic [1:0]  fault_code
);

`ifdef LIS3DH_XYZ_EN
    localparam int NB = 6;
`else
    localparam int NB = 2;
`endif
    localparam int BW = 8 * NB;

    typedef enum logic [3:0] {
        S_IDLE, S_WHO0, S_WHO1, S_CFG0, S_CFG1, S_WAIT, S_RD, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic          out_q, out_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-9:0] part_q, part_d;
    logic [BW-1:0] smp_q, smp_d;
    logic          valid_q, valid_d;
    logic          ok_q, ok_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic          done;
    logic          byte_st;
    logic [BW-1:0] full;

    assign done    = out_q && xfer_done;
    assign byte_st = state_q inside {S_WHO0, S_WHO1, S_CFG0, S_CFG1, S_RD};
    assign full    = {xfer_rx, part_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            part_q  <= '0;
            smp_q   <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tcnt_q  <= tcnt_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            smp_q   <= smp_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        tcnt_d     = tcnt_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        part_d     = part_q;
        smp_d      = smp_q;
        valid_d    = 1'b0;
        ok_d       = ok_q;
        fault_d    = fault_q;
        code_d     = code_q;
        xfer_start = 1'b0;
        xfer_tx    = 8'h00;
        xfer_hold  = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_WHO0;
            S_WHO0: begin
                xfer_tx   = 8'h8F;
                xfer_hold = 1'b1;
                if (done) state_d = S_WHO1;
            end
            S_WHO1: begin
                if (done) begin
                    if (xfer_rx != WHOAMI_EXP) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = 2'd1;
                        ok_d    = 1'b0;
                    end else begin
                        state_d = S_CFG0;
                    end
                end
            end
            S_CFG0: begin
                xfer_tx   = 8'h20;
                xfer_hold = 1'b1;
                if (done) state_d = S_CFG1;
            end
            S_CFG1: begin
                xfer_tx = CTRL1_VAL;
                if (done) begin
                    ok_d    = 1'b1;
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (wcnt_q == POLL_DIV - 32'd1) begin
                    state_d = S_RD;
                    idx_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            S_RD: begin
                xfer_tx   = (idx_q == 3'd0) ? 8'hE8 : 8'h00;
                xfer_hold = (idx_q != 3'(NB));
                if (done) begin
                    for (int i = 0; i < NB - 1; i++) begin
                        if (idx_q == 3'(i + 1)) part_d[8*i +: 8] = xfer_rx;
                    end
                    // Samples only change once the whole burst has arrived.
                    if (idx_q == 3'(NB)) begin
                        smp_d   = full;
                        valid_d = 1'b1;
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_FAULT: ok_d = 1'b0;
            default: state_d = S_IDLE;
        endcase

        if (out_q && !done) begin
            if ({1'b0, tcnt_q} + 17'd1 >= {1'b0, XFER_TIMEOUT}) begin
                state_d   = S_FAULT;
                out_d     = 1'b0;
                fault_d   = 1'b1;
                code_d    = 2'd2;
                ok_d      = 1'b0;
                xfer_hold = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end
        if (done) begin
            out_d  = 1'b0;
            tcnt_d = '0;
        end
        if (byte_st && !out_q && !xfer_busy) begin
            xfer_start = 1'b1;
            out_d      = 1'b1;
            tcnt_d     = 16'd1;
        end
    end

    assign sample_x     = smp_q[15:0];
`ifdef LIS3DH_XYZ_EN
    assign sample_y     = smp_q[31:16];
    assign sample_z     = smp_q[47:32];
`endif
    assign sample_valid = valid_q;
    assign dev_ok       = ok_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;

endmodule

// File: tb/tb_lis3dh_poller.sv
// Scoreboard bench for lis3dh_poller: random SPI slave, byte/sample reference model.
// Honors LIS3DH_XYZ_EN for the 6-byte burst variant.
module tb_lis3dh_poller;

`ifdef LIS3DH_XYZ_EN
    localparam int NB = 6;
`else
    localparam int NB = 2;
`endif
    localparam int         PDIV  = 50;
    localparam int         TMO   = 16;
    localparam logic [7:0] WHO   = 8'h33;
    localparam logic [7:0] CTRL1 = 8'h57;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        xfer_start, xfer_hold;
    logic        xfer_busy = 1'b0;
    logic        xfer_done = 1'b0;
    logic [7:0]  xfer_tx;
    logic [7:0]  xfer_rx = 8'h00;
    logic [15:0] sample_x;
`ifdef LIS3DH_XYZ_EN
    logic [15:0] sample_y, sample_z;
`endif
    logic        sample_valid, dev_ok, fault;
    logic [1:0]  fault_code;

    always #5 clk = ~clk;

    lis3dh_poller #(
        .POLL_DIV(32'd50),
        .WHOAMI_EXP(8'h33),
        .CTRL1_VAL(8'h57),
        .XFER_TIMEOUT(16'd16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .xfer_start(xfer_start),
        .xfer_tx(xfer_tx),
        .xfer_hold(xfer_hold),
        .xfer_busy(xfer_busy),
        .xfer_done(xfer_done),
        .xfer_rx(xfer_rx),
        .sample_x(sample_x),
`ifdef LIS3DH_XYZ_EN
        .sample_y(sample_y),
        .sample_z(sample_z),
`endif
        .sample_valid(sample_valid),
        .dev_ok(dev_ok),
        .fault(fault),
        .fault_code(fault_code)
    );

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_tx[$];
    logic [47:0] exp_smp[$];
    logic [7:0]  rsp[$];
    logic [47:0] last_smp = '0;
    int          cyc = 0;
    int          smp_seen = 0;
    int          nstart = 0;
    int          drop_at = -1;
    int          start_cyc = 0;
    int          last_v = -1;
    bit          kill = 1'b0;
    int          s_lat;
    bit          s_drop;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [47:0] dut_smp();
`ifdef LIS3DH_XYZ_EN
        return {sample_z, sample_y, sample_x};
`else
        return {32'h0, sample_x};
`endif
    endfunction

    function automatic void chk_reset_vals(string tag);
        chk({tag, "_start"}, 48'(xfer_start), 48'd0);
        chk({tag, "_tx"}, 48'(xfer_tx), 48'd0);
        chk({tag, "_hold"}, 48'(xfer_hold), 48'd0);
        chk({tag, "_sample"}, dut_smp(), 48'd0);
        chk({tag, "_flags"}, 48'({sample_valid, dev_ok, fault, fault_code}), 48'd0);
    endfunction

    // Expected SPI byte stream and samples derived from the command protocol.
    task automatic model(input logic [7:0] who, input int nb, input bit partial,
                         input bit fixed, input logic [47:0] d0, input logic [47:0] d1);
        logic [47:0] smp;
        logic [7:0]  b;
        exp_tx.push_back({1'b1, 8'h8F}); rsp.push_back(8'($urandom));
        exp_tx.push_back({1'b0, 8'h00}); rsp.push_back(who);
        if (who == WHO) begin
            exp_tx.push_back({1'b1, 8'h20}); rsp.push_back(8'($urandom));
            exp_tx.push_back({1'b0, CTRL1}); rsp.push_back(8'($urandom));
            for (int k = 0; k < nb + int'(partial); k++) begin
                exp_tx.push_back({1'b1, 8'hE8}); rsp.push_back(8'($urandom));
                smp = '0;
                for (int i = 0; i < NB; i++) begin
                    if (fixed && k < 2) b = (k == 0) ? d0[8*i +: 8] : d1[8*i +: 8];
                    else b = 8'($urandom);
                    if (k < nb || i == 0) begin
                        exp_tx.push_back({i != NB - 1, 8'h00});
                        rsp.push_back(b);
                    end
                    smp[8*i +: 8] = b;
                end
                if (k < nb) exp_smp.push_back(smp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (xfer_start) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start got tx %h want no start", xfer_tx);
                end else begin
                    logic [8:0] e;
                    e = exp_tx.pop_front();
                    chk("tx_byte", 48'({xfer_hold, xfer_tx}), 48'(e));
                    if (e[7:0] == 8'hE8) begin
                        chk("dev_ok_at_rd", 48'(dev_ok), 48'd1);
                        if (last_v >= 0) chk("poll_gap", 48'(cyc - last_v), 48'(PDIV));
                    end
                    if (e[7:0] == 8'h8F) chk("dev_ok_at_who", 48'(dev_ok), 48'd0);
                end
            end
            if (sample_valid) begin
                smp_seen++;
                last_v = cyc;
                if (exp_smp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got %h want none", dut_smp());
                end else begin
                    last_smp = exp_smp.pop_front();
                    chk("sample", dut_smp(), last_smp);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset && xfer_start) begin
                s_drop = (nstart == drop_at);
                start_cyc = cyc;
                nstart++;
                @(posedge clk);
                #1 xfer_busy = 1'b1;
                s_lat = s_drop ? (1 << 30) : int'($urandom_range(1, 5));
                for (int k = 0; k < s_lat && !kill; k++) @(posedge clk);
                if (!kill) begin
                    #1;
                    xfer_rx = (rsp.size() != 0) ? rsp.pop_front() : 8'h00;
                    xfer_done = 1'b1;
                    @(posedge clk);
                    #1;
                end
                xfer_done = 1'b0;
                xfer_busy = 1'b0;
                xfer_rx = 8'h00;
            end
        end
    end

    task automatic do_reset(input bit check_vals);
        reset = 1'b0;
        kill = 1'b1;
        #1;
        if (check_vals) chk_reset_vals("midburst");
        chk("leftover_tx", 48'(exp_tx.size()), 48'd0);
        chk("leftover_smp", 48'(exp_smp.size()), 48'd0);
        repeat (3) @(posedge clk);
        exp_tx.delete();
        exp_smp.delete();
        rsp.delete();
        kill = 1'b0;
        nstart = 0;
        drop_at = -1;
        last_v = -1;
        smp_seen = 0;
        last_smp = '0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_samples(input int n);
        int t = 0;
        while (smp_seen < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("samples_seen", 48'(smp_seen), 48'(n));
    endtask

    task automatic wait_fault(output int at);
        int t = 0;
        at = -1;
        while (!fault && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (fault) at = cyc;
        chk("fault_seen", 48'(fault), 48'd1);
    endtask

    task automatic check_ok_end();
        chk("ok_dev_ok", 48'(dev_ok), 48'd1);
        chk("ok_fault", 48'({fault, fault_code}), 48'd0);
        chk("ok_sample_hold", dut_smp(), last_smp);
    endtask

    initial begin
        logic [47:0] d0, d1;
        logic [7:0]  w;
        int          fat;
        int          n;
`ifdef LIS3DH_XYZ_EN
        d0 = 48'h060504030201;
        d1 = 48'h0C0B0A090807;
`else
        d0 = 48'h000000001234;
        d1 = 48'h00000000ABCD;
`endif
        #3 reset = 1'b0;
        #1 chk_reset_vals("por");
        repeat (3) @(posedge clk);

        model(WHO, 2, 1'b0, 1'b1, d0, d1);
        release_rst();
        wait_samples(2);
        check_ok_end();
        do_reset(1'b0);

        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 3));
            model(WHO, n, 1'b0, 1'b0, d0, d1);
            release_rst();
            wait_samples(n);
            check_ok_end();
            do_reset(1'b0);
        end

        for (int r = 0; r < 2; r++) begin
            w = (r == 0) ? 8'h32 : 8'($urandom);
            if (w == WHO) w = w ^ 8'h01;
            model(w, 0, 1'b0, 1'b0, d0, d1);
            release_rst();
            wait_fault(fat);
            repeat ((r == 0) ? 10000 : 200) @(negedge clk);
            chk("who_code", 48'({fault, fault_code}), 48'({1'b1, 2'd1}));
            chk("who_dev_ok", 48'(dev_ok), 48'd0);
            chk("who_hold", 48'(xfer_hold), 48'd0);
            do_reset(1'b0);
        end

        model(WHO, 1, 1'b1, 1'b0, d0, d1);
        drop_at = NB + 6;
        release_rst();
        wait_fault(fat);
        chk("tmo_latency", 48'(fat - start_cyc), 48'(TMO));
        chk("tmo_code", 48'(fault_code), 48'd2);
        chk("tmo_hold", 48'(xfer_hold), 48'd0);
        chk("tmo_dev_ok", 48'(dev_ok), 48'd0);
        chk("tmo_sample", dut_smp(), last_smp);
        repeat (100) @(negedge clk);
        do_reset(1'b0);

        model(WHO, 1, 1'b1, 1'b0, d0, d1);
        release_rst();
        n = 0;
        while (!(nstart == NB + 7 && xfer_busy && !xfer_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("rd1_reached", 48'(nstart), 48'(NB + 7));
        do_reset(1'b1);
        model(WHO, 1, 1'b0, 1'b0, d0, d1);
        release_rst();
        wait_samples(1);
        check_ok_end();
        do_reset(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lis3dh_poller.md
Name: lis3dh_poller

Overview:
- Transaction sequencer sitting between the top-level control logic and the byte-level SPI master inside dut; that master drives spi_sck/spi_mosi/spi_csn toward the LIS3DH.
- After reset it checks WHO_AM_I, writes CTRL_REG1, then periodically burst-reads OUT_X_L/OUT_X_H.
- Presents each assembled 16-bit sample with a one-cycle valid strobe for leds/UART consumers.

Parameters:
- POLL_DIV, 32'd1000: clk cycles spent in WAIT between the end of one read burst and the start of the next; legal range 1..2^32-1.
- WHOAMI_EXP, 8'h33: expected WHO_AM_I value.
- CTRL1_VAL, 8'h57: byte written to CTRL_REG1 (0x20).
- XFER_TIMEOUT, 16'd4096: maximum clk cycles from xfer_start to xfer_done before a fault is declared.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- xfer_start  out  1  one-cycle pulse; requests one SPI byte from the master.
- xfer_tx  out  8  byte to shift out; stable from xfer_start until xfer_done.
- xfer_hold  out  1  1 = keep csn low after this byte; 0 = release csn after this byte.
- xfer_busy  in  1  master is shifting.
- xfer_done  in  1  one-cycle pulse at byte end.
- xfer_rx  in  8  received byte; valid only in the xfer_done cycle.
- sample_x  out  16  last X sample, {OUT_X_H, OUT_X_L}.
- sample_valid  out  1  one-cycle pulse when sample_x updates.
- dev_ok  out  1  WHO_AM_I matched and CTRL_REG1 write completed.
- fault  out  1  sticky error flag.
- fault_code  out  2  fault cause: 0 = none, 1 = WHO_AM_I mismatch, 2 = timeout.

Behaviour:
- Reset values (asserted asynchronously while reset is low): xfer_start 0, xfer_tx 8'h00, xfer_hold 0, sample_x 0, sample_valid 0, dev_ok 0, fault 0, fault_code 0, state IDLE, all counters 0.
- Byte issue rule: xfer_start is pulsed only in a cycle where xfer_busy=0 and no byte is outstanding. The FSM advances only on xfer_done. xfer_rx is captured in the xfer_done cycle.
- States, in order:
  - IDLE: go to WHO0 one cycle after reset deasserts.
  - WHO0: send 8'h8F, hold=1.
  - WHO1: send 8'h00, hold=0. Compare the captured byte with WHOAMI_EXP. Mismatch -> FAULT with code 1.
  - CFG0: send 8'h20, hold=1.
  - CFG1: send CTRL1_VAL, hold=0. On its xfer_done, dev_ok becomes 1.
  - WAIT: count POLL_DIV cycles, then go to RD0.
  - RD0: send 8'hE8 (read + auto-increment + 0x28), hold=1.
  - RD1: send 8'h00, hold=1; capture xl.
  - RD2: send 8'h00, hold=0; capture xh.
  - RD2 completion: on the cycle after RD2's xfer_done, sample_x <= {xh, xl} and sample_valid=1 for exactly that cycle. Same cycle: go to WAIT, WAIT counter cleared.
- Timeout: a counter runs while a byte is outstanding. If it reaches XFER_TIMEOUT with no xfer_done, go to FAULT with code 2; xfer_hold goes 0 that same cycle.
- FAULT: terminal. dev_ok=0, fault=1, no further xfer_start. Exit only via reset.
- sample_x holds its last value through WAIT and FAULT. A partial burst never updates it.
- xfer_done received while no byte is outstanding is ignored.
- Reset asserted mid-burst: all outputs return to reset values immediately (xfer_hold=0 releases csn). Sequence restarts from WHO0.
- POLL_DIV=1: exactly one WAIT cycle between bursts.

Optional Feature:
- Macro: LIS3DH_XYZ_EN.
- Defined:
  - Adds outputs sample_y[15:0] and sample_z[15:0], both reset to 0.
  - The read burst becomes 8'hE8 followed by 6 dummy bytes: X_L, X_H, Y_L, Y_H, Z_L, Z_H. Only the last byte has hold=0.
  - All three samples update together with a single sample_valid pulse.
- Undefined: 3-byte X-only burst as described above; the ports sample_y and sample_z do not exist.

Test Plan:
- Reset release; slave returns 8'h33, then X_L=8'h34, X_H=8'h12 -> byte sequence 8F,00,20,57,E8,00,00; dev_ok=1 after the 57 byte; sample_x=16'h1234 with one sample_valid pulse.
- Slave returns WHO_AM_I=8'h32 -> fault=1, fault_code=1, dev_ok=0, no xfer_start afterwards for 10000 cycles.
- Master never pulses xfer_done after RD1 start, XFER_TIMEOUT=16 -> fault_code=2 exactly 16 cycles after xfer_start; xfer_hold=0; sample_x unchanged.
- POLL_DIV=50, two consecutive bursts -> RD0 xfer_start occurs 50 cycles after the previous sample_valid; two pulses seen; sample_x tracks the second pair (8'hCD, 8'hAB -> 16'hABCD).
- Reset pulled low during RD1 -> all outputs at reset values in the same cycle; after release the sequence restarts with 8'h8F.
- With LIS3DH_XYZ_EN and bytes 01,02,03,04,05,06 -> sample_x=16'h0201, sample_y=16'h0403, sample_z=16'h0605; a single valid pulse; hold=0 only on the 7th byte.
